pipeline_dmem_responder: RTL and testbench
==========================================

// Module: pipeline_dmem_responder
// PURPOSE
//   Data-memory responder for the pipelined MIPS core's MEM stage.
//   The core (or a bus adapter) issues one load or store request. This block holds the 32-bit word memory.
//   It inserts a configurable number of wait states, then returns a single-cycle ack with read data.
//   It replaces the core's zero-latency internal array when memory timing must be modelled.
// PARAMETERS
//   DEPTH        1024  number of 32-bit words in the memory
//   ADDR_W       10    index bits used from addr; DEPTH must equal 2**ADDR_W
//   WAIT_STATES  2     extra cycles between request accept and ack (0..255)
// PORTS
//   clock  in   1   single clock; all state updates on posedge
//   reset  in   1   asynchronous, active-high reset
//   req    in   1   request strobe; sampled only in IDLE
//   we     in   1   1 = store (SW), 0 = load (LW); sampled with req
//   addr   in   32  word address (EX_MEM_ALUOut); sampled with req
//   wdata  in   32  store data (EX_MEM_B); sampled with req
//   busy   out  1   1 while a request is outstanding (WAIT or RESP)
//   ack    out  1   one-cycle completion pulse
//   rdata  out  32  load data; valid in the ack cycle; held until the next ack
//   err    out  1   address-range error, valid in the ack cycle
// BEHAVIOUR
//   Reset (async): state=IDLE, busy=0, ack=0, rdata=0, err=0, wait counter=0.
//     Memory contents are NOT cleared.
//   FSM, all transitions on posedge clock:
//     IDLE: if req=1, latch we/addr/wdata, load cnt=WAIT_STATES, go to WAIT, busy<=1.
//     WAIT: if cnt==0, perform the access, set ack<=1, go to RESP; else cnt<=cnt-1.
//     RESP: ack<=0, busy<=0, go to IDLE.
//   Latency: accept at edge E0 -> ack rises at edge E0+WAIT_STATES+1, falls one edge later.
//   Throughput: with req held high, one request per WAIT_STATES+3 cycles.
//   Access happens at the ack-rising edge:
//     store: mem[idx] <= latched wdata; rdata unchanged.
//     load: rdata <= mem[idx].
//   idx = latched addr[ADDR_W-1:0]; upper addr bits are handled per CONFIGURATION.
//   Any req/we/addr/wdata change while busy=1 is ignored; requests are not queued.
//   Read-after-write: a load accepted after a store's ack returns the stored value.
//   Reset mid-request: the request is abandoned, the pending store is never written, and no ack is issued.
//   WAIT_STATES=0: ack rises one edge after accept.
// CONFIGURATION
//   Macro DMEM_RANGE_CHECK_EN:
//     Defined: if latched addr >= DEPTH, the ack cycle has err=1.
//       A store is suppressed; a load returns rdata=32'hDEADBEEF.
//       In-range accesses give err=0.
//     Undefined: upper addr bits are ignored, so addresses alias modulo DEPTH.
//       err is tied to 0; no range logic is synthesised.
// TESTING
//   T1: WAIT_STATES=2, store addr=5 data=32'h12345678 accepted at E0
//       -> busy=1 from E0; ack only in cycle E3..E4; err=0.
//   T2: load addr=5 after T1 -> ack at E0+3 with rdata=32'h12345678; rdata holds after ack falls.
//   T3: WAIT_STATES=0, req held high with loads to addrs 1,2,3
//       -> acks exactly every 3 cycles, each 1 cycle wide, with mem[1], mem[2], mem[3] in order.
//   T4: accept a load, then toggle req/addr/we every cycle while busy
//       -> exactly one ack, with data from the originally latched address.
//   T5: mem[7]=32'hA5A5A5A5; accept store addr=7 data=0; assert reset in WAIT
//       -> busy/ack/err/rdata=0 immediately; a later load of addr 7 returns 32'hA5A5A5A5.
//   T6: store addr=1030 data=32'hCAFEF00D, then load addr=6
//       -> with DMEM_RANGE_CHECK_EN: store ack has err=1, load returns the old mem[6];
//       -> without it: load of addr 6 returns 32'hCAFEF00D, err=0.

Source files
------------

// File: rtl/pipeline_dmem_responder.sv
// Word data memory for the pipelined MIPS MEM stage: one request at a time, WAIT_STATES wait cycles, single-cycle ack.
// Optional address range checking is enabled by defining DMEM_RANGE_CHECK_EN.
`timescale 1ns/1ps
module pipeline_dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_nxt;
  logic                w_accept;
  logic                w_access;
  logic                w_wr_en;
  logic                w_oor;
  logic                r_we;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdata;
  logic                r_busy;
  logic                r_ack;
  logic [31:0]         r_rdata;
  logic [31:0]         r_mem [DEPTH];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = 8'(WAIT_STATES);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_access    = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_ack   <= (w_state_nxt == S_RESP);
      if (w_accept) begin
        r_we    <= we;
        r_idx   <= addr[ADDR_W-1:0];
        r_wdata <= wdata;
      end
      if (w_access && !r_we) begin
        r_rdata <= w_oor ? 32'hDEADBEEF : r_mem[r_idx];
      end
    end
  end

`ifdef DMEM_RANGE_CHECK_EN
  logic r_oor;
  logic r_err;

  // Range flag is captured at accept so the full address need not be held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_oor <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_oor <= (addr >= 32'(DEPTH));
      end
      r_err <= w_access & r_oor;
    end
  end

  assign w_oor = r_oor;
  assign err   = r_err;
`else
  logic w_unused_addr_hi;

  assign w_unused_addr_hi = ^addr[31:ADDR_W];
  assign w_oor            = 1'b0;
  assign err              = 1'b0;
`endif

  // Memory has no reset; reset forces IDLE, so an abandoned store never reaches it.
  assign w_wr_en = w_access & r_we & ~w_oor;

  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign busy  = r_busy;
  assign ack   = r_ack;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_pipeline_dmem_responder.sv
// Scoreboard bench for pipeline_dmem_responder: instance 0 uses WAIT_STATES=2, instance 1 uses WAIT_STATES=0.
`timescale 1ns/1ps
module tb_pipeline_dmem_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]  rst_v;
  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [1:0]  busy_v;
  logic [1:0]  ack_v;
  logic [1:0]  err_v;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [31:0] rdata_v [2];

  pipeline_dmem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_STATES(2)) u_dut_ws2 (
    .clock(clock), .reset(rst_v[0]), .req(req_v[0]), .we(we_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .busy(busy_v[0]), .ack(ack_v[0]),
    .rdata(rdata_v[0]), .err(err_v[0])
  );

  pipeline_dmem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_STATES(0)) u_dut_ws0 (
    .clock(clock), .reset(rst_v[1]), .req(req_v[1]), .we(we_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .busy(busy_v[1]), .ack(ack_v[1]),
    .rdata(rdata_v[1]), .err(err_v[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mdl [2][1024];
  logic [31:0] last_rd [2];
  logic [31:0] hold_rd [2];
  logic [1:0]  prev_ack = 2'b00;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic int unsigned ws(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic range_err(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return (a >= 32'd1024);
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  // Monitor: pops an expectation on every ack; between acks rdata must hold.
  task automatic mon(input int d);
    exp_t e;
    if (rst_v[d]) begin
      prev_ack[d] = 1'b0;
      return;
    end
    if (ack_v[d]) begin
      chk($sformatf("ack width d%0d", d), 32'(prev_ack[d]), 32'd0);
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected ack d%0d: ack=1 at cycle %0d, required no ack", d, cyc);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("rdata d%0d", d), rdata_v[d], e.rdata);
        chk($sformatf("err d%0d", d), 32'(err_v[d]), 32'(e.err));
        chk($sformatf("ack cycle d%0d", d), cyc, e.cyc);
        hold_rd[d] = e.rdata;
      end
    end else begin
      chk($sformatf("rdata hold d%0d", d), rdata_v[d], hold_rd[d]);
    end
    prev_ack[d] = ack_v[d];
  endtask

  always @(negedge clock) begin
    mon(0);
    mon(1);
  end

  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic hold, output int unsigned acc);
    exp_t e;
    int   n;
    logic oor;
    @(negedge clock);
    n = 0;
    while (busy_v[d] && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (busy_v[d]) begin
      checks++;
      errors++;
      $display("FAIL busy timeout d%0d: busy=1, required 0", d);
    end
    req_v[d]   = 1'b1;
    we_v[d]    = w;
    addr_v[d]  = a;
    wdata_v[d] = wd;
    oor        = range_err(a);
    e.err      = oor;
    if (w) begin
      if (!oor) mdl[d][a[9:0]] = wd;
      e.rdata = last_rd[d];
    end else begin
      e.rdata    = oor ? 32'hDEADBEEF : mdl[d][a[9:0]];
      last_rd[d] = e.rdata;
    end
    @(posedge clock);
    #1;
    acc   = cyc;
    e.cyc = cyc + ws(d) + 1;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    chk($sformatf("busy after accept d%0d", d), 32'(busy_v[d]), 32'd1);
    if (!hold) req_v[d] = 1'b0;
  endtask

  initial begin
    int unsigned acc_a, acc_b, acc_c, acc_x;
    logic [31:0] saved;
    rst_v = 2'b11;
    req_v = 2'b00;
    we_v  = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr_v[d]  = '0;
      wdata_v[d] = '0;
      last_rd[d] = '0;
      hold_rd[d] = '0;
      for (int i = 0; i < 1024; i++) mdl[d][i] = '0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset busy d%0d", d), 32'(busy_v[d]), 32'd0);
      chk($sformatf("reset ack d%0d", d), 32'(ack_v[d]), 32'd0);
      chk($sformatf("reset err d%0d", d), 32'(err_v[d]), 32'd0);
      chk($sformatf("reset rdata d%0d", d), rdata_v[d], 32'd0);
    end
    @(negedge clock);
    @(negedge clock);
    rst_v = 2'b00;

    // T1/T2: store then load with two wait states
    issue(0, 1'b1, 32'd5, 32'h12345678, 1'b0, acc_x);
    issue(0, 1'b0, 32'd5, 32'h0, 1'b0, acc_x);
    issue(0, 1'b1, 32'd9, 32'h00000099, 1'b0, acc_x);
    issue(0, 1'b1, 32'd6, 32'h66666666, 1'b0, acc_x);
    issue(0, 1'b1, 32'd7, 32'hA5A5A5A5, 1'b0, acc_x);

    // T4: inputs churn while busy; only the latched load of addr 5 may complete
    issue(0, 1'b0, 32'd5, 32'h0, 1'b0, acc_x);
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (!busy_v[0]) break;
      req_v[0]   = ~req_v[0];
      we_v[0]    = ~we_v[0];
      addr_v[0]  = addr_v[0] ^ 32'h0000000C;
      wdata_v[0] = 32'hBAD00000 + 32'(n);
    end
    req_v[0] = 1'b0;
    we_v[0]  = 1'b0;
    issue(0, 1'b0, 32'd9, 32'h0, 1'b0, acc_x);

    // T5: reset during WAIT abandons the store to addr 7
    saved = mdl[0][7];
    issue(0, 1'b1, 32'd7, 32'h0, 1'b0, acc_x);
    @(negedge clock);
    rst_v[0] = 1'b1;
    #1;
    chk("T5 busy", 32'(busy_v[0]), 32'd0);
    chk("T5 ack", 32'(ack_v[0]), 32'd0);
    chk("T5 err", 32'(err_v[0]), 32'd0);
    chk("T5 rdata", rdata_v[0], 32'd0);
    q0.delete();
    mdl[0][7]  = saved;
    last_rd[0] = '0;
    hold_rd[0] = '0;
    @(negedge clock);
    rst_v[0] = 1'b0;
    issue(0, 1'b0, 32'd7, 32'h0, 1'b0, acc_x);

    // T6: out-of-range / aliasing address 1030 (index 6)
    issue(0, 1'b1, 32'd1030, 32'hCAFEF00D, 1'b0, acc_x);
    issue(0, 1'b0, 32'd6, 32'h0, 1'b0, acc_x);
    issue(0, 1'b0, 32'd1030, 32'h0, 1'b0, acc_x);

    // T3: zero wait states, req held high across back-to-back loads
    issue(1, 1'b1, 32'd1, 32'h11111111, 1'b0, acc_x);
    issue(1, 1'b1, 32'd2, 32'h22222222, 1'b0, acc_x);
    issue(1, 1'b1, 32'd3, 32'h33333333, 1'b0, acc_x);
    issue(1, 1'b0, 32'd1, 32'h0, 1'b1, acc_a);
    issue(1, 1'b0, 32'd2, 32'h0, 1'b1, acc_b);
    issue(1, 1'b0, 32'd3, 32'h0, 1'b0, acc_c);
    chk("T3 spacing 1-2", acc_b - acc_a, 32'd3);
    chk("T3 spacing 2-3", acc_c - acc_b, 32'd3);

    for (int n = 0; n < 50; n++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clock);
    end
    @(negedge clock);
    chk("pending d0", 32'(q0.size()), 32'd0);
    chk("pending d1", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
